ahb_slave_mux: RTL

Parametrised AHB-Lite slave-side interconnect for the uncore, next generation of the fixed-width read/response mux and hsel delay register. It takes one-hot address-phase region selects from the address decoder, gates them to NSLV slaves, and holds a registered data-phase select. It multiplexes HRDATA/HREADY/HRESP back to the core. A built-in default slave returns a spec-compliant two-cycle ERROR for unmapped or multiply-decoded accesses, and a saturating error counter is exposed.

---
 rtl/ahb_slave_mux.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/ahb_slave_mux.sv
// AHB-Lite slave-side interconnect: gates one-hot address-phase region selects to NSLV slaves,
// registers the data-phase select, muxes HRDATA/HREADY/HRESP back to the master and provides a
// built-in default slave that answers unmapped or multiply-decoded accesses with a two-cycle
// ERROR. A saturating counter records every ERROR this block generates itself.
//
// Optional feature: define AHB_TIMEOUT_EN to add a stall watchdog. A slave that holds the bus for
// TIMEOUT cycles is abandoned: the block takes over with its own two-cycle ERROR and pulses
// SlvAbort. With the macro undefined a stalled slave stalls the bus indefinitely.
module ahb_slave_mux #(
  parameter int unsigned NSLV     = 8,
  parameter int unsigned DW       = 64,
  parameter int unsigned ERRCNT_W = 16,
  parameter int unsigned TIMEOUT  = 256
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  input  logic [NSLV-1:0]     HSELRegions,
  input  logic [1:0]          HTRANS,
  output logic [NSLV-1:0]     HSELS,
  input  logic [NSLV*DW-1:0]  HRDATAS,
  input  logic [NSLV-1:0]     HREADYOUTS,
  input  logic [NSLV-1:0]     HRESPS,
  output logic [DW-1:0]       HRDATA,
  output logic                HREADY,
  output logic                HRESP,
  output logic [NSLV-1:0]     HSELD,
  output logic [ERRCNT_W-1:0] ErrCnt,
  output logic                SlvAbort
);

  // Reject configurations outside the supported range at elaboration time.
  if (NSLV < 2 || NSLV > 16 || TIMEOUT < 2 || ERRCNT_W < 1 || DW < 1) begin : gen_bad_param
    $error("ahb_slave_mux: unsupported parameter combination");
  end

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StErr1 = 2'd1,
    StErr2 = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [NSLV-1:0]       hseld_q, hseld_d;
  logic [ERRCNT_W-1:0]   errcnt_q, errcnt_d;

  logic                  valid;
  logic                  onehot;
  logic                  decerr;
  logic                  abort;

  logic [DW-1:0]         slv_hrdata;
  logic                  slv_hready;
  logic                  slv_hresp;

  // HTRANS[0] only distinguishes SEQ from NONSEQ (or BUSY from IDLE); decoding ignores it.
  logic                  unused_htrans;
  assign unused_htrans = HTRANS[0];

  // Address-phase decode: only a clean one-hot select on an active transfer reaches a slave.
  always_comb begin
    valid  = HTRANS[1];
    onehot = (HSELRegions != '0) && ((HSELRegions & (HSELRegions - NSLV'(1))) == '0);
    decerr = valid && !onehot;
    HSELS  = (valid && onehot) ? HSELRegions : '0;
  end

  // Data-phase slave mux; an empty select behaves as a zero-wait OKAY responder.
  always_comb begin
    slv_hrdata = '0;
    slv_hready = 1'b1;
    slv_hresp  = 1'b0;
    for (int i = 0; i < NSLV; i++) begin
      if (hseld_q[i]) begin
        slv_hrdata = HRDATAS[i*DW +: DW];
        slv_hready = HREADYOUTS[i];
        slv_hresp  = HRESPS[i];
      end
    end
  end

  // Response to the master: the default slave overrides the slave mux while it owns the bus.
  always_comb begin
    HRDATA = '0;
    HREADY = 1'b1;
    HRESP  = 1'b0;
    case (state_q)
      StErr1: begin
        HREADY = 1'b0;
        HRESP  = 1'b1;
      end
      StErr2: begin
        HREADY = 1'b1;
        HRESP  = 1'b1;
      end
      default: begin
        HRDATA = slv_hrdata;
        HREADY = slv_hready;
        HRESP  = slv_hresp;
      end
    endcase
  end

`ifdef AHB_TIMEOUT_EN
  localparam int unsigned StallW = $clog2(TIMEOUT + 1);

  logic [StallW-1:0] stall_q, stall_d;
  logic              slvabort_q;
  logic              stalled;

  // Watchdog: count cycles a selected slave holds HREADY low; the TIMEOUT-th such cycle aborts.
  always_comb begin
    stalled = (hseld_q != '0) && !HREADY;
    abort   = stalled && (stall_q == StallW'(TIMEOUT - 1));
    stall_d = stall_q;
    if (HREADY || abort) begin
      stall_d = '0;
    end else if (stalled) begin
      stall_d = stall_q + StallW'(1);
    end
  end

  // Stall counter and one-cycle abort pulse, aligned with the first ERROR cycle.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      stall_q    <= '0;
      slvabort_q <= 1'b0;
    end else begin
      stall_q    <= stall_d;
      slvabort_q <= abort;
    end
  end

  assign SlvAbort = slvabort_q;
`else
  assign abort    = 1'b0;
  assign SlvAbort = 1'b0;
`endif

  // Default-slave next state, data-phase select and saturating error count.
  always_comb begin
    state_d  = state_q;
    hseld_d  = hseld_q;
    errcnt_d = errcnt_q;

    case (state_q)
      StIdle: begin
        if (abort || (HREADY && decerr)) begin
          state_d = StErr1;
        end
      end
      StErr1: state_d = StErr2;
      StErr2: state_d = decerr ? StErr1 : StIdle;
      default: state_d = StIdle;
    endcase

    // An aborted slave is dropped so its late HREADYOUT cannot reach the master.
    if (abort) begin
      hseld_d = '0;
    end else if (HREADY) begin
      hseld_d = HSELS;
    end

    // ERR1 never loops on itself, so heading there always marks a fresh error.
    if ((state_d == StErr1) && (errcnt_q != '1)) begin
      errcnt_d = errcnt_q + ERRCNT_W'(1);
    end
  end

  // State registers; everything clears asynchronously on reset.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= StIdle;
      hseld_q  <= '0;
      errcnt_q <= '0;
    end else begin
      state_q  <= state_d;
      hseld_q  <= hseld_d;
      errcnt_q <= errcnt_d;
    end
  end

  assign HSELD  = hseld_q;
  assign ErrCnt = errcnt_q;

endmodule
